read_ram_unloader: RTL and testbench
====================================

Name: read_ram_unloader

Overview:
- Downstream neighbour of the NAND read controller.
- Once the controller has filled the read-page RAM with 8192 data bytes (addr 0..8191) and two validity flags (addr 8192 = first half, addr 8193 = second half; 0x55 = uncorrectable/invalid), this block drains the RAM to a host-side byte stream with valid/ready handshake.
- Tags each byte with its half's validity and optionally skips invalid halves.
- Connects to the read-only port of the shared read-page RAM.

Parameters:
DATA_BYTES, 8192, page data bytes in RAM
HALF_BYTES, 4096, bytes per ECC validity half
RAM_AW, 15, RAM address width
FLAG_ADDR0, 8192, first-half flag address
FLAG_ADDR1, 8193, second-half flag address
FLAG_INVALID, 8'h55, flag value meaning half invalid
SKIP_INVALID, 0, 1 = do not emit bytes of invalid halves

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse: page plus flags present in RAM
ram_en  out  1  RAM read enable
ram_addr  out  RAM_AW  RAM read address
ram_dataout  in  8  RAM read data, valid the cycle after ram_en
m_data  out  8  stream byte
m_valid  out  1  stream byte valid
m_ready  in  1  sink accepts byte
m_last  out  1  final emitted byte of page
m_half_bad  out  1  current byte belongs to an invalid half
half_bad  out  2  latched flags {half1, half0}, valid from FLAG capture until next start
busy  out  1  unload in progress
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset: rst is asynchronous, active-high. All state clears: FSM to IDLE, FIFO empty, in-flight bit clear, half_bad=0. With the FSM in IDLE, every output reads 0. Reset mid-operation abandons the page; no done pulse is produced.
- ram_en and ram_addr are combinational from registered state; no other RAM outputs exist (write never driven).
- FSM states:
  - IDLE: start → FLAG0. Start is ignored while busy.
  - FLAG0: ram_en=1, addr=FLAG_ADDR0 → FLAG1.
  - FLAG1: ram_en=1, addr=FLAG_ADDR1; half_bad[0] <= (ram_dataout==FLAG_INVALID) → STREAM.
  - STREAM: captures half_bad[1] in its first cycle; issues data reads.
  - DRAIN: waits for FIFO empty → DONE.
  - DONE: done=1 for one cycle → IDLE.
- busy=1 in every state except IDLE.
- Read pointer rd_ptr (13 bits) starts at 0, or at HALF_BYTES if SKIP_INVALID and half_bad[0].
- Half-1 skip decision is made when rd_ptr reaches HALF_BYTES, since half_bad[1] is known by then. If SKIP_INVALID and both halves are bad: STREAM issues nothing and goes directly to DONE, with zero bytes emitted.
- Issue rule in STREAM: ram_en=1 when (fifo_count + inflight < 2) or (m_valid && m_ready). Data read in cycle N is pushed into a 2-entry FIFO at the end of cycle N+1.
- STREAM → DRAIN when the last address is issued: 8191, or 4095 when half 1 is skipped.
- m_data, m_valid, m_half_bad, m_last come from the FIFO head. They are held stable while m_valid && !m_ready.
- m_half_bad = half_bad[address bit 12 of that byte]. m_last is set only on the final emitted byte.
- Latency: start sampled at edge 0 gives first m_valid in cycle 5. With m_ready held high, throughput is 1 byte/clk; an unskipped page finishes 8192 handshakes later.
- done asserts in the cycle after the m_last handshake.
- Flag values other than FLAG_INVALID (e.g. 0x00, 0x54) count as valid.

Decomposition:
- Shared package holds: DATA_BYTES, HALF_BYTES, FLAG_ADDR0/1, FLAG_INVALID constants (shared with the read controller), and the unloader state enum.
- One sub-module, rd_byte_skid_fifo: 2-entry FIFO, 10-bit payload {last, half_bad, data}, with push/pop/count outputs and async reset.

Test Plan:
- Both flags 0x00, RAM[i]=i[7:0], m_ready=1 → 8192 bytes 0x00..0xFF repeating; first m_valid in cycle 5 after start; m_last on byte 8191; done one cycle later; half_bad=2'b00.
- Flag0=0x55, SKIP_INVALID=0 → all 8192 bytes emitted; m_half_bad=1 for bytes 0..4095, 0 for 4096..8191; half_bad=2'b01.
- SKIP_INVALID=1, flag1=0x55 → 4096 bytes (addr 0..4095) emitted; m_last on addr 4095; no ram_en issued to addr ≥4096.
- SKIP_INVALID=1, both flags 0x55 → no m_valid; done pulses; only addr 8192/8193 read.
- Random m_ready (~40% duty) → byte sequence identical to golden, no drop or duplicate; m_data stable while stalled; fifo_count never exceeds 2.
- rst asserted at byte 1000, then a new start → outputs 0 during reset; new page streams from byte 0; start pulsed mid-stream is ignored.

Source files
------------

// File: rtl/read_ram_unloader_pkg.sv
// read_ram_unloader_pkg: page layout constants shared with the read controller, and the unloader state encoding
package read_ram_unloader_pkg;
  localparam int DATA_BYTES = 8192;
  localparam int HALF_BYTES = 4096;
  localparam int RAM_AW = 15;
  localparam int FLAG_ADDR0 = 8192;
  localparam int FLAG_ADDR1 = 8193;
  localparam logic [7:0] FLAG_INVALID = 8'h55;
  typedef enum logic [2:0] {IDLE, FLAG0, FLAG1, STREAM, DRAIN, DONE} unl_state_t;
endpackage

// File: rtl/read_ram_unloader_fifo.sv
// rd_byte_skid_fifo: two-entry FIFO carrying {last, half_bad, data} from the RAM read port to the stream
module rd_byte_skid_fifo #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      wp <= wp ^ push;
      rp <= rp ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign dout = mem[rp];
endmodule

// File: rtl/read_ram_unloader.sv
// read_ram_unloader: drains the read-page RAM (validity flags first, then data) to a valid/ready byte stream
module read_ram_unloader
  import read_ram_unloader_pkg::*;
#(
  parameter int         DATA_BYTES   = read_ram_unloader_pkg::DATA_BYTES,
  parameter int         HALF_BYTES   = read_ram_unloader_pkg::HALF_BYTES,
  parameter int         RAM_AW       = read_ram_unloader_pkg::RAM_AW,
  parameter int         FLAG_ADDR0   = read_ram_unloader_pkg::FLAG_ADDR0,
  parameter int         FLAG_ADDR1   = read_ram_unloader_pkg::FLAG_ADDR1,
  parameter logic [7:0] FLAG_INVALID = read_ram_unloader_pkg::FLAG_INVALID,
  parameter bit         SKIP_INVALID = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [7:0]        ram_dataout,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              m_half_bad,
  output logic [1:0]        half_bad,
  output logic              busy,
  output logic              done
);
  localparam int PW = $clog2(DATA_BYTES);
  unl_state_t state, state_n;
  logic [PW-1:0] rd_ptr;
  logic [1:0] count;
  logic [9:0] head;
  logic first, inflight, inf_last, inf_half, issue, h1_bad, stop, last_addr, pop;
  // half 1's flag is still on the RAM bus during the first STREAM cycle
  assign h1_bad = first ? ram_dataout == FLAG_INVALID : half_bad[1];
  assign stop = SKIP_INVALID && h1_bad && rd_ptr == PW'(HALF_BYTES);
  assign last_addr = rd_ptr == PW'(DATA_BYTES - 1) || (SKIP_INVALID && h1_bad && rd_ptr == PW'(HALF_BYTES - 1));
  assign m_valid = count != 2'd0;
  assign pop = m_valid && m_ready;
  assign {m_last, m_half_bad, m_data} = m_valid ? head : '0;
  assign issue = state == STREAM && !stop && (count + {1'b0, inflight} < 2'd2 || pop);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    ram_en = 1'b0;
    ram_addr = '0;
    done = 1'b0;
    case (state)
      IDLE: state_n = start ? FLAG0 : IDLE;
      FLAG0: begin
        ram_en = 1'b1;
        ram_addr = RAM_AW'(FLAG_ADDR0);
        state_n = FLAG1;
      end
      FLAG1: begin
        ram_en = 1'b1;
        ram_addr = RAM_AW'(FLAG_ADDR1);
        state_n = STREAM;
      end
      STREAM: begin
        ram_en = issue;
        ram_addr = RAM_AW'(rd_ptr);
        state_n = stop ? DONE : issue && last_addr ? DRAIN : STREAM;
      end
      DRAIN: state_n = (count == 2'd0 && !inflight) || (pop && m_last) ? DONE : DRAIN;
      DONE: begin
        done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      half_bad <= 2'b00;
      first <= 1'b0;
      inflight <= 1'b0;
      inf_last <= 1'b0;
      inf_half <= 1'b0;
    end else begin
      state <= state_n;
      first <= state == FLAG1;
      inflight <= issue;
      if (issue) begin
        inf_last <= last_addr;
        inf_half <= rd_ptr >= PW'(HALF_BYTES);
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (state == IDLE && start) half_bad <= 2'b00;
      if (state == FLAG1) begin
        half_bad[0] <= ram_dataout == FLAG_INVALID;
        rd_ptr <= SKIP_INVALID && ram_dataout == FLAG_INVALID ? PW'(HALF_BYTES) : '0;
      end
      if (first) half_bad[1] <= ram_dataout == FLAG_INVALID;
    end
  rd_byte_skid_fifo #(.W(10)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .pop(pop),
    .din({inf_last, half_bad[inf_half], ram_dataout}),
    .dout(head),
    .count(count)
  );
endmodule

// File: tb/tb_read_ram_unloader.sv
// tb_read_ram_unloader: scoreboard bench driving a plain-skip and a skip-invalid unloader from one RAM image
module tb_read_ram_unloader;
  logic clk, rst, m_ready;
  logic [1:0] start, ram_en, m_valid, m_last, m_half_bad, busy, done;
  logic [14:0] ram_addr [2];
  logic [7:0] ram_q [2];
  logic [7:0] m_data [2];
  logic [1:0] half_bad [2];
  logic [7:0] mem [0:8193];
  int n_cmp = 0, n_bad = 0;

  read_ram_unloader #(.SKIP_INVALID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .ram_en(ram_en[0]), .ram_addr(ram_addr[0]),
    .ram_dataout(ram_q[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready),
    .m_last(m_last[0]), .m_half_bad(m_half_bad[0]), .half_bad(half_bad[0]), .busy(busy[0]), .done(done[0])
  );
  read_ram_unloader #(.SKIP_INVALID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .ram_en(ram_en[1]), .ram_addr(ram_addr[1]),
    .ram_dataout(ram_q[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready),
    .m_last(m_last[1]), .m_half_bad(m_half_bad[1]), .half_bad(half_bad[1]), .busy(busy[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_en[0]) ram_q[0] <= mem[ram_addr[0]];
    if (ram_en[1]) ram_q[1] <= mem[ram_addr[1]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {ram_en, m_valid, m_last, m_half_bad, busy, done, half_bad[0], half_bad[1], m_data[0], m_data[1]};
  endfunction

  task automatic run_page(input int s, input logic [7:0] f0, input logic [7:0] f1, input int duty,
                          input int rst_at, input int start_at, input bit inc);
    logic [9:0] exp_q [$];
    logic [9:0] cur, held;
    bit b0, b1, stalled, last_hs, fin, hs, sp;
    int cyc, first_cyc, flag_reads, bad_addr, n_hs, nbytes;
    b0 = f0 == 8'h55;
    b1 = f1 == 8'h55;
    for (int i = 0; i < 8192; i++) mem[i] = inc ? i[7:0] : 8'($urandom);
    mem[8192] = f0;
    mem[8193] = f1;
    for (int i = 0; i < 8192; i++)
      if (!(s == 1 && (i < 4096 ? b0 : b1))) exp_q.push_back({1'b0, i < 4096 ? b0 : b1, mem[i]});
    nbytes = exp_q.size();
    if (nbytes > 0) begin
      cur = exp_q[nbytes-1];
      cur[9] = 1'b1;
      exp_q[nbytes-1] = cur;
    end
    {stalled, last_hs, fin, sp} = '0;
    {first_cyc, flag_reads, bad_addr, n_hs} = '0;
    held = '0;
    @(negedge clk) start[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[s] = 1'b0;
    cyc = 1;
    while (!fin) begin
      if (n_hs == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_outs", all_outs(), 0);
        chk("rst_addr", {ram_addr[0], ram_addr[1]}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("no_done_after_rst", {done, busy}, 0);
        return;
      end
      m_ready = $urandom_range(99) < duty;
      start[s] = n_hs == start_at && !sp;
      if (start[s]) sp = 1'b1;
      #1;
      if (ram_en[s]) begin
        if (ram_addr[s] >= 8192) flag_reads++;
        else if (s == 1 && (ram_addr[s] < 4096 ? b0 : b1)) bad_addr++;
      end
      cur = {m_last[s], m_half_bad[s], m_data[s]};
      if (stalled) chk("stall_hold", {m_valid[s], cur}, {1'b1, held});
      if (m_valid[s] && first_cyc == 0) first_cyc = cyc;
      if (last_hs || done[s]) begin
        chk("done_pulse", done[s], last_hs || nbytes == 0);
        fin = 1'b1;
      end else begin
        hs = m_valid[s] && m_ready;
        if (hs) begin
          chk("q_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("byte", cur, exp_q.pop_front());
          n_hs++;
        end
        last_hs = hs && m_last[s];
        stalled = m_valid[s] && !m_ready;
        held = cur;
      end
      if (cyc > 30000) begin
        chk("timeout", cyc, 0);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    start[s] = 1'b0;
    chk("left_in_q", exp_q.size(), 0);
    chk("n_bytes", n_hs, nbytes);
    chk("half_bad", half_bad[s], {b1, b0});
    chk("flag_reads", flag_reads, 2);
    chk("skip_addr", bad_addr, 0);
    if (nbytes > 0) chk("first_valid_cyc", first_cyc, 5);
    else chk("no_valid", first_cyc, 0);
    @(posedge clk);
    @(negedge clk);
    chk("idle_after", {busy[s], m_valid[s], ram_en[s], done[s]}, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    rst = 1'b0;
    run_page(0, 8'h00, 8'h00, 100, -1, -1, 1'b1);
    run_page(0, 8'h55, 8'h00, 100, -1, -1, 1'b0);
    run_page(1, 8'h00, 8'h55, 100, -1, -1, 1'b0);
    run_page(1, 8'h55, 8'h55, 100, -1, -1, 1'b0);
    run_page(0, 8'h54, 8'h00, 40, -1, 500, 1'b0);
    run_page(1, 8'h55, 8'h54, 60, -1, 300, 1'b0);
    run_page(0, 8'h00, 8'h00, 100, 1000, -1, 1'b0);
    run_page(0, 8'h00, 8'h55, 100, -1, -1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
